// File: rtl/program_loader_pkg.sv
// Shared processor definitions: instruction width and the boot loader state encoding.
package program_loader_pkg;

  localparam int WORD_W = 19;

  typedef enum logic [3:0] {
    HDR_HI,
    HDR_LO,
    B0,
    B1,
    B2,
    WRITE,
    CHK,
    RUN,
    ERR
  } loader_state_e;

endpackage

// File: rtl/loader_word_packer.sv
// Packs three stream bytes into one instruction word; the top bits of the first byte fall off the end.
module loader_word_packer
  import program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [7:0]        byte_data,
  output logic [WORD_W-1:0] word
);

  logic [WORD_W-1:0] shift_q;
  logic [WORD_W-1:0] shift_d;

  // Shifting by a byte into a 19-bit register leaves {b0[2:0], b1, b2} after three loads.
  always_comb begin
    shift_d = shift_q;
    if (clear) begin
      shift_d = '0;
    end else if (load) begin
      shift_d = {shift_q[WORD_W-9:0], byte_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign word = shift_q;

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses a framed byte stream, writes instruction memory and releases the CPU
// once the image checksum verifies.
module program_loader #(
  parameter int ADDR_W = 12,
  parameter int WORD_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  import program_loader_pkg::*;

  localparam int         DEPTH   = 2 ** ADDR_W;
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  loader_state_e state_q, state_d;
  logic [7:0]        hdr_hi_q, hdr_hi_d;
  logic [16:0]       count_q, count_d;
  logic [16:0]       word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        chk_q, chk_d;
  logic              accept;
  logic              pack_load;
  logic              pack_clear;
  logic [16:0]       hdr_count;

  assign hdr_count = {1'b0, hdr_hi_q, byte_data};

  always_comb begin
    state_d    = state_q;
    hdr_hi_d   = hdr_hi_q;
    count_d    = count_q;
    word_cnt_d = word_cnt_q;
    addr_d     = addr_q;
    chk_d      = chk_q;
    byte_ready = 1'b0;
    pack_load  = 1'b0;

    case (state_q)
      HDR_HI, HDR_LO, B0, B1, B2, CHK: byte_ready = 1'b1;
      default:                         byte_ready = 1'b0;
    endcase

    accept = byte_valid && byte_ready;

    // The checksum byte itself is compared, never folded into the running XOR.
    if (accept && (state_q != CHK)) begin
      chk_d = chk_q ^ byte_data;
    end

    case (state_q)
      HDR_HI: begin
        if (accept) begin
          hdr_hi_d = byte_data;
          state_d  = HDR_LO;
        end
      end
      HDR_LO: begin
        if (accept) begin
          count_d = hdr_count;
          if (hdr_count > DEPTH_W) begin
            state_d = ERR;
          end else if (hdr_count == 17'd0) begin
            state_d = CHK;
          end else begin
            state_d = B0;
          end
        end
      end
      B0: begin
        pack_load = accept;
        if (accept) state_d = B1;
      end
      B1: begin
        pack_load = accept;
        if (accept) state_d = B2;
      end
      B2: begin
        pack_load = accept;
        if (accept) state_d = WRITE;
      end
      WRITE: begin
        word_cnt_d = word_cnt_q + 17'd1;
        addr_d     = addr_q + 1'b1;
        state_d    = (word_cnt_q + 17'd1 == count_q) ? CHK : B0;
      end
      CHK: begin
        if (accept) begin
          state_d = (byte_data == chk_q) ? RUN : ERR;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HDR_HI;
      hdr_hi_q   <= '0;
      count_q    <= '0;
      word_cnt_q <= '0;
      addr_q     <= '0;
      chk_q      <= '0;
    end else begin
      state_q    <= state_d;
      hdr_hi_q   <= hdr_hi_d;
      count_q    <= count_d;
      word_cnt_q <= word_cnt_d;
      addr_q     <= addr_d;
      chk_q      <= chk_d;
    end
  end

  assign pack_clear = (state_q == HDR_HI);

  loader_word_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (pack_clear),
    .load      (pack_load),
    .byte_data (byte_data),
    .word      (imem_wdata)
  );

  // All status outputs decode the registered state, so they appear one cycle after the causing byte.
  assign imem_we   = (state_q == WRITE);
  assign imem_addr = addr_q;
  assign done      = (state_q == RUN);
  assign error     = (state_q == ERR);
  assign cpu_reset = (state_q != RUN);

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader sitting directly upstream of the processor. It receives a framed byte stream, packs 19-bit instruction words, and writes them sequentially into instruction memory. It holds the processor in reset until the image is fully written and its checksum verifies. After that it releases `cpu_reset` and goes quiescent until the next `reset`.

## Interface
Parameters:
- `ADDR_W`, 12, instruction-memory address width; capacity `DEPTH = 2**ADDR_W` words
- `WORD_W`, 19, instruction width; fixed by the ISA, not to be overridden

Ports:
- `clk` in 1: the single clock; all state changes on the rising edge
- `reset` in 1: synchronous, active-high
- `byte_valid` in 1: upstream byte present
- `byte_data` in 8: upstream byte
- `byte_ready` out 1: loader accepts a byte this cycle
- `imem_we` out 1: one-cycle instruction-memory write strobe
- `imem_addr` out ADDR_W: write address
- `imem_wdata` out WORD_W: write data
- `cpu_reset` out 1: reset driven to the processor; high while loading
- `done` out 1: image loaded and verified
- `error` out 1: load failed; sticky until `reset`

## Operation
- **Byte acceptance.** A byte is accepted on a rising edge with `byte_valid && byte_ready`. `byte_valid` gaps of any length are legal.
- **Frame format.**
  - Count N, 16-bit big-endian (`HDR_HI`, `HDR_LO`).
  - N words of 3 bytes each (`B0`, `B1`, `B2`). Word = `{b0[2:0], b1, b2}`; `b0[7:3]` is ignored.
  - One checksum byte (`CHK`). It must equal the XOR of every preceding frame byte, header included.
- **States and transitions.**
  - `HDR_HI` → `HDR_LO` → either `B0` (N>0) or `CHK` (N=0).
  - If N > DEPTH, go to `ERR` right after `HDR_LO` is accepted.
  - Word loop: `B0` → `B1` → `B2` → `WRITE` → either `B0` (more words) or `CHK` (last word).
  - `CHK` → `RUN` on checksum match, `ERR` on mismatch.
  - `RUN` and `ERR` are terminal until `reset`.
- **`byte_ready`.** High in `HDR_HI`, `HDR_LO`, `B0`–`B2` and `CHK`. Low in `WRITE`, `RUN` and `ERR`.
- **`WRITE`.**
  - `imem_we`=1 for exactly one cycle; `imem_addr` = word index, starting at 0.
  - The address counter increments at the end of `WRITE`.
  - The word counter compares against N to select the next state.
- **Checksum.** Running 8-bit XOR register, cleared on `reset`, updated on every accepted byte except the checksum byte.
- **Outputs by terminal state.**
  - `RUN`: `cpu_reset`=0, `done`=1.
  - `ERR`: `cpu_reset`=1, `error`=1.
  - Bytes offered in `RUN` or `ERR` are never accepted.

## Timing
- **Reset values.** State `HDR_HI`; `byte_ready`=1; `imem_we`=0; `imem_addr`=0; `imem_wdata`=0; `cpu_reset`=1; `done`=0; `error`=0; checksum=0; word count=0.
- **Write latency.** `imem_we` asserts the cycle after `B2` is accepted. `imem_addr`/`imem_wdata` are registered and stable that cycle.
- **Throughput.** Minimum 4 cycles per word (3 byte cycles plus 1 write cycle).
- **Release.** `done`, `cpu_reset`=0 and `error` become visible the cycle after the checksum byte is accepted. `cpu_reset` falls in the same cycle `done` rises.
- **Reset mid-load.** Return to `HDR_HI` on the next edge and clear all counters. Already-written memory is not erased. Any pending write is dropped (`imem_we`=0 in the reset cycle's result).
- **Boundaries.**
  - N=DEPTH: last write at address DEPTH-1, no wrap.
  - N=DEPTH+1: `ERR`.
  - `reset` asserted together with `byte_valid`: the byte is not accepted.

## Structure
- **Shared package.** The state enum (`HDR_HI, HDR_LO, B0, B1, B2, WRITE, CHK, RUN, ERR`) and `WORD_W=19` live in the processor's shared package, so the memory and the top level agree on instruction width.
- **Sub-module.** `loader_word_packer`: 3-byte shift/pack register with `load` and `clear` inputs producing `WORD_W` bits. The FSM, counters and checksum stay in `program_loader`.
- **Integration.** At the processor top, `cpu_reset` drives the Processor's `reset`; the loader takes the board `reset`.

## Test plan
- **Normal load.** Bytes 00 02 01 23 45 07 AB CD 04 → writes 0x12345@0 and 0x7ABCD@1; `done`=1 and `cpu_reset`=0 one cycle after byte 04.
- **Empty image.** Bytes 00 00 00 → no `imem_we`; `done`=1.
- **Checksum mismatch.** The first frame with final byte 05 → both writes happen; `error`=1, `cpu_reset` stays 1, `byte_ready`=0 afterwards.
- **Oversize count.** Header 10 01 with ADDR_W=12 → `ERR` the cycle after the second byte; zero writes.
- **Gapped stream.** The first frame with random 0–5 cycle `byte_valid` gaps → identical writes and `done`. `imem_we` is never high two cycles in a row, and no byte is accepted while `byte_ready`=0.
- **Reset mid-load.** `reset` after byte 01 23 of the first frame, then the full first frame → only complete-frame writes at addresses 0/1; `done`=1, `error`=0.
